barrett_mod_mul: RTL and testbench
==================================

Name: barrett_mod_mul

Overview:
- Pipelined modular multiplier for the NTT butterfly datapath. Computes out = (a * b) mod q using Barrett reduction.
- Sits directly upstream of the modular adder/subtractor stage. Typically b is the twiddle factor and a is the odd operand.
- Carries an aligned pass-through operand (the even operand), so the downstream stage receives u and (w*v mod q) in the same cycle.
- Valid/ready handshake with full-pipeline stall on downstream backpressure.

Parameters:
- W, 32, operand and modulus width; equals the codebase data width.
- LAT, 5, fixed pipeline latency in cycles from input accept to out_valid; not user-tunable, exposed for benches.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- q  input  W  modulus; quasi-static; must satisfy 2^(W-1) < q < 2^W.
- mu  input  W+1  Barrett constant floor(2^(2W)/q); quasi-static, precomputed by software.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  W  multiplicand, required < q.
- b  input  W  multiplier (twiddle), required < q.
- pass_in  input  W  side-band operand, delayed unchanged.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- out  output  W  (a*b) mod q.
- pass_out  output  W  pass_in of the same beat.

Behaviour:
- Reset (reset=0, async): every pipeline valid bit clears and every data register clears. out=0, pass_out=0, out_valid=0. in_ready reads 1 after reset deasserts. A reset mid-operation discards all in-flight beats; none are emitted.
- Global enable: en = !(out_valid && !out_ready). in_ready = en (combinational). Pipeline registers, including valid bits, advance only when en=1.
- Beat acceptance: a beat is accepted when in_valid && in_ready. Bubbles (in_valid=0 while en=1) propagate as valid=0.
- Stages, each registered on en:
  - S1: latch a, b, pass.
  - S2: x = a*b, 2W bits.
  - S3: t = ((x >> (W-1)) * mu) >> (W+1), W+1 bits. Keep x.
  - S4: r = x[W+1:0] - (t*q)[W+1:0], computed mod 2^(W+2). Guaranteed 0 <= r < 3q.
  - S5: if r >= 2q then r - 2q, else if r >= q then r - q, else r. Register as out, with pass_out.
- Latency: an accepted beat appears on out/out_valid exactly 5 enabled cycles later. Throughput is 1 beat/cycle when out_ready=1.
- Stall: while out_valid=1 and out_ready=0, out, pass_out and all stages hold, and in_ready=0. No beat is lost or duplicated.
- Simultaneous events: out_ready=1 with in_valid=1 and a full pipeline is legal. Output transfer and input accept occur in the same cycle.
- Ordering: strict FIFO ordering; beats are never reordered.
- Out-of-range inputs (a or b >= q, or q/mu violating their constraints): the result is unspecified, but the handshake still behaves correctly. A sim-only assertion flags the violation.
- Changing q or mu while beats are in flight is illegal; the controller changes them only when the pipe is empty.

Test Plan:
- W=16, q=65521, mu=65551.
  - a=2, b=3 -> out=6 exactly 5 cycles after accept.
  - a=65520, b=65520 -> out=1 (the r >= q correction path).
  - a=65520, b=2 -> out=65519.
  - a=0, b=40000 -> out=0.
  - pass_in=0x1234 is carried through and appears with its beat.
- Streaming: 200 random in-range beats, in_valid held high, out_ready=1. Results match the golden (a*b)%q every cycle, back-to-back, in order.
- Backpressure: while streaming, drop out_ready for 7 cycles.
  - in_ready=0 and out/pass_out are held constant throughout.
  - After release there are no drops or duplicates, checked with sequence-numbered pass_in.
- Bubbles: alternate in_valid 1/0 with random out_ready. Output count equals accepted count, and the valid pattern is preserved.
- Reset mid-flight: accept 3 beats, then assert reset=0 for 2 cycles.
  - out_valid=0, out=0 and pass_out=0 immediately (async).
  - After release, no stale beats emerge, and a fresh beat a=2, b=3 returns 6 at latency 5.
- Correction boundaries: use directed pairs from a precomputed list that force r in [q, 2q) and in [2q, 3q) at S4. The final out is < q and correct in both cases.

Source files
------------

// File: rtl/barrett_mod_mul.sv
// Barrett modular multiplier: out = (a * b) mod q, five-stage pipeline.
// A side-band operand travels alongside each beat so that downstream logic
// sees it in the same cycle as the product. A single global enable freezes
// every stage, valid bits included, while the output beat is not taken.
module barrett_mod_mul #(
    parameter int W   = 32,
    parameter int LAT = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] q,
    input  logic [W:0]   mu,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] pass_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [W-1:0] pass_out
);

    // Stage data registers
    logic [W-1:0]   a1_q, a1_d;
    logic [W-1:0]   b1_q, b1_d;
    logic [2*W-1:0] x2_q, x2_d;
    logic [W+1:0]   x3_q, x3_d;
    logic [W:0]     t3_q, t3_d;
    logic [W+1:0]   r4_q, r4_d;
    logic [W-1:0]   out_q, out_d;

    // Valid bits and side-band operand, one slot per stage
    logic [LAT-1:0] vld_q, vld_d;
    logic [W-1:0]   pass_q [LAT];
    logic [W-1:0]   pass_d [LAT];

    logic           en;
    logic [W+1:0]   q1_ext;
    logic [W+1:0]   q2_ext;

    // Enable, handshake and next-state datapath for every stage
    always_comb begin
        en       = !(vld_q[LAT-1] && !out_ready);
        in_ready = en;

        // S1: capture operands
        a1_d = a;
        b1_d = b;

        // S2: full-width product
        x2_d = (2*W)'(a1_q) * (2*W)'(b1_q);

        // S3: quotient estimate; only the low W+2 bits of x matter for the remainder
        t3_d = (W+1)'(((2*W+2)'(x2_q[2*W-1:W-1]) * (2*W+2)'(mu)) >> (W+1));
        x3_d = x2_q[W+1:0];

        // S4: partial remainder, exact modulo 2^(W+2) because r < 3q < 2^(W+2)
        r4_d = x3_q - (W+2)'(t3_q) * (W+2)'(q);

        // S5: at most two conditional subtractions bring r into [0, q)
        q1_ext = {2'b00, q};
        q2_ext = {1'b0, q, 1'b0};
        if (r4_q >= q2_ext) begin
            out_d = W'(r4_q - q2_ext);
        end else if (r4_q >= q1_ext) begin
            out_d = W'(r4_q - q1_ext);
        end else begin
            out_d = W'(r4_q);
        end

        // Valid bits and side-band operand shift one stage per enabled cycle
        vld_d     = {vld_q[LAT-2:0], in_valid};
        pass_d[0] = pass_in;
        for (int i = 1; i < LAT; i++) begin
            pass_d[i] = pass_q[i-1];
        end
    end

    // Pipeline registers: async clear, advance only on global enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1_q  <= '0;
            b1_q  <= '0;
            x2_q  <= '0;
            x3_q  <= '0;
            t3_q  <= '0;
            r4_q  <= '0;
            out_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pass_q[i] <= '0;
            end
        end else if (en) begin
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            x2_q  <= x2_d;
            x3_q  <= x3_d;
            t3_q  <= t3_d;
            r4_q  <= r4_d;
            out_q <= out_d;
            vld_q <= vld_d;
            for (int i = 0; i < LAT; i++) begin
                pass_q[i] <= pass_d[i];
            end
        end
    end

    assign out       = out_q;
    assign pass_out  = pass_q[LAT-1];
    assign out_valid = vld_q[LAT-1];

`ifndef SYNTHESIS
    // Flag accepted beats with unreduced operands or an illegal modulus/constant
    assert property (@(posedge clk) disable iff (!reset)
        (in_valid && in_ready) |->
            ((a < q) && (b < q) && q[W-1] && (q[W-2:0] != '0) && mu[W]))
        else $error("barrett_mod_mul: operand or modulus out of range");
`endif

endmodule

// File: tb/tb_barrett_mod_mul.sv
// Directed and streaming bench for barrett_mod_mul at W=16.
module tb_barrett_mod_mul;

    localparam int W   = 16;
    localparam int LAT = 5;

    localparam logic [W-1:0] Q1  = 16'd65521;
    localparam logic [W:0]   MU1 = 17'd65551;
    localparam logic [W-1:0] Q2  = 16'd65281;
    localparam logic [W:0]   MU2 = 17'd65791;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] q;
    logic [W:0]   mu;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pass_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [W-1:0] pass_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    barrett_mod_mul #(.W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .q         (q),
        .mu        (mu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .pass_in   (pass_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .pass_out  (pass_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    function automatic logic [W-1:0] golden(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic [W-1:0] qv);
        longint prod;
        prod = longint'(av) * longint'(bv);
        return W'(prod % longint'(qv));
    endfunction

    // One beat in, then confirm it appears exactly LAT cycles later
    task automatic directed(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] pv, input logic [W-1:0] ev);
        @(negedge clk);
        a = av; b = bv; pass_in = pv; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT - 2) @(negedge clk);
        check({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_out"}, out, ev);
        check({tag, "_pass"}, pass_out, pv);
        $display("%s: a=%0d b=%0d -> out=%0d pass=%h", tag, av, bv, out, pass_out);
    endtask

    // Stream n random beats; either a 7-cycle stall window or alternating bubbles
    task automatic stream(input string tag, input int n, input bit bubbles, input int stall_at,
                          input logic [W-1:0] seq_base);
        logic [W-1:0] exp_out_q [$];
        logic [W-1:0] exp_pass_q [$];
        logic [W-1:0] av, bv;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit have = 1'b0;
        while ((sent < n || exp_out_q.size() != 0) && cyc < n * 6 + 100) begin
            @(negedge clk);
            if (bubbles) out_ready = 1'($urandom_range(1, 0));
            else         out_ready = !(cyc >= stall_at && cyc < stall_at + 7);
            if (sent < n && (!bubbles || (cyc % 2) == 0)) begin
                if (!have) begin
                    av   = W'($urandom_range(int'(q) - 1, 0));
                    bv   = W'($urandom_range(int'(q) - 1, 0));
                    have = 1'b1;
                end
                a = av; b = bv; pass_in = W'(seq_base + W'(sent)); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_ready) check({tag, "_in_ready_free"}, in_ready, 1);
            if (!bubbles && !out_ready) begin
                check({tag, "_stall_in_ready"}, in_ready, 0);
                check({tag, "_stall_valid"}, out_valid, 1);
                if (exp_out_q.size() != 0) begin
                    check({tag, "_stall_out"}, out, exp_out_q[0]);
                    check({tag, "_stall_pass"}, pass_out, exp_pass_q[0]);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out_q.size() == 0) begin
                    check({tag, "_spurious_beat"}, out_valid, 0);
                end else begin
                    check({tag, "_out"}, out, exp_out_q[0]);
                    check({tag, "_seq"}, pass_out, exp_pass_q[0]);
                    $display("%s: beat %0d out=%0d pass=%h", tag, got, out, pass_out);
                    void'(exp_out_q.pop_front());
                    void'(exp_pass_q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_out_q.push_back(golden(av, bv, q));
                exp_pass_q.push_back(pass_in);
                sent++;
                have = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_accepted"}, sent, n);
        check({tag, "_received"}, got, n);
    endtask

    initial begin
        reset = 1'b1; q = Q1; mu = MU1; in_valid = 1'b0;
        a = '0; b = '0; pass_in = '0; out_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_pass_out", pass_out, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed vectors, q = 65521
        directed("d_2x3", 16'd2, 16'd3, 16'h1234, 16'd6);
        directed("d_qm1_sq", 16'd65520, 16'd65520, 16'h0001, 16'd1);
        directed("d_qm1_x2", 16'd65520, 16'd2, 16'h0002, 16'd65519);
        directed("d_zero", 16'd0, 16'd40000, 16'h0003, 16'd0);

        // Back-to-back streaming with a 7-cycle backpressure window
        stream("stream", 200, 1'b0, 50, 16'h0000);
        // Alternating bubbles with random backpressure
        stream("bubble", 60, 1'b1, 0, 16'h4000);

        // Reset while beats are in flight
        @(negedge clk);
        out_ready = 1'b1;
        a = 16'd300;   b = 16'd7;     pass_in = 16'hA000; in_valid = 1'b1;
        @(negedge clk);
        a = 16'd1000;  b = 16'd1000;  pass_in = 16'hA001;
        @(negedge clk);
        a = 16'd40000; b = 16'd40000; pass_in = 16'hA002;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_pre_valid", out_valid, 1);
        check("mid_pre_out", out, 2100);
        check("mid_pre_pass", pass_out, 16'hA000);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_pass", pass_out, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_in_ready", in_ready, 1);
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check("mid_no_stale", out_valid, 0);
        end
        directed("mid_fresh", 16'd2, 16'd3, 16'h00F0, 16'd6);

        // Correction boundaries with q = 65281: r lands in [2q,3q) then [q,2q)
        @(negedge clk);
        q = Q2; mu = MU2;
        directed("bnd_2q", 16'd65280, 16'd65153, 16'h0B02, 16'd128);
        directed("bnd_1q", 16'd65280, 16'd65280, 16'h0B01, 16'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
